// File: rtl/lamp_fpu_sqrt_ctrl.sv
// Issue controller and round/pack back-end for the lampFPU square-root core.
// Unpacks a bfloat16 operand, starts the core, then rounds and packs its result.
module lamp_fpu_sqrt_ctrl #(
    parameter int LAMP_FLOAT_DW   = 16,
    parameter int LAMP_FLOAT_E_DW = 8,
    parameter int LAMP_FLOAT_F_DW = 7,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_i,
    input  logic                                   isInv_i,
    input  logic [LAMP_FLOAT_DW-1:0]               op_i,
    output logic                                   ready_o,
    output logic                                   valid_o,
    output logic [LAMP_FLOAT_DW-1:0]               result_o,
    output logic                                   overflow_o,
    output logic                                   error_o,
    output logic                                   doSqrt_o,
    output logic                                   doInvSqrt_o,
    output logic                                   s_o,
    output logic [LAMP_FLOAT_F_DW:0]               extF_o,
    output logic [LAMP_FLOAT_E_DW:0]               extE_o,
    output logic [$clog2(LAMP_FLOAT_F_DW+1)-1:0]   nlz_o,
    output logic                                   isZ_o,
    output logic                                   isInf_o,
    output logic                                   isSNAN_o,
    output logic                                   isQNAN_o,
    input  logic                                   sq_s_i,
    input  logic [LAMP_FLOAT_E_DW-1:0]             sq_e_i,
    input  logic [LAMP_FLOAT_F_DW+4:0]             sq_f_i,
    input  logic                                   sq_valid_i,
    input  logic                                   sq_isToRound_i
);

    localparam int F_DW  = LAMP_FLOAT_F_DW;
    localparam int E_DW  = LAMP_FLOAT_E_DW;
    localparam int NLZ_W = $clog2(F_DW + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [LAMP_FLOAT_DW-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    typedef struct packed {
        logic             s;
        logic [F_DW:0]    ext_f;
        logic [E_DW:0]    ext_e;
        logic [NLZ_W-1:0] nlz;
        logic             is_z;
        logic             is_inf;
        logic             is_snan;
        logic             is_qnan;
    } unpack_t;

    state_t                   state_q, state_d;
    logic                     is_inv_q, is_inv_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [LAMP_FLOAT_DW-1:0] result_q, result_d;
    logic                     overflow_q, overflow_d;
    logic                     error_q, error_d;
    unpack_t                  unpack_q, unpack_d, unpack_op;

    // Operand field decode, only captured on acceptance.
    logic [E_DW-1:0] op_e;
    logic [F_DW-1:0] op_f;
    logic            e_zero, e_ones, f_zero;

    assign op_e   = op_i[LAMP_FLOAT_DW-2 -: E_DW];
    assign op_f   = op_i[F_DW-1:0];
    assign e_zero = (op_e == '0);
    assign e_ones = &op_e;
    assign f_zero = (op_f == '0);

    always_comb begin
        unpack_op         = '0;
        unpack_op.s       = op_i[LAMP_FLOAT_DW-1];
        unpack_op.ext_f   = {~e_zero, op_f};
        unpack_op.ext_e   = e_zero ? (E_DW+1)'(1) : {1'b0, op_e};
        unpack_op.is_z    = e_zero & f_zero;
        unpack_op.is_inf  = e_ones & f_zero;
        unpack_op.is_qnan = e_ones & ~f_zero & op_f[F_DW-1];
        unpack_op.is_snan = e_ones & ~f_zero & ~op_f[F_DW-1];
        // Ascending scan: the highest set bit writes last; zero keeps the F_DW clamp.
        unpack_op.nlz     = NLZ_W'(F_DW);
        for (int i = 0; i <= F_DW; i++) begin
            if (unpack_op.ext_f[i]) unpack_op.nlz = NLZ_W'(F_DW - i);
        end
    end

    // Round-to-nearest-even on the core result; the hidden bit is implied.
    logic [F_DW-1:0]          sq_frac;
    logic                     round_up;
    logic [F_DW:0]            frac_sum;
    logic [E_DW-1:0]          exp_rnd;
    logic                     rnd_ovf;
    logic [LAMP_FLOAT_DW-1:0] rnd_result;
    logic                     unused_hidden;

    assign unused_hidden = sq_f_i[F_DW+4];
    assign sq_frac       = sq_f_i[F_DW+3:4];
    assign round_up      = sq_isToRound_i & sq_f_i[3] & ((|sq_f_i[2:0]) | sq_frac[0]);
    assign frac_sum      = {1'b0, sq_frac} + {{F_DW{1'b0}}, round_up};
    assign exp_rnd       = sq_e_i + {{(E_DW-1){1'b0}}, frac_sum[F_DW]};
    assign rnd_ovf       = frac_sum[F_DW] & (&exp_rnd);
    // On a mantissa carry frac_sum's low bits are already zero, so Inf needs no extra mux.
    assign rnd_result    = {sq_s_i, exp_rnd, frac_sum[F_DW-1:0]};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        is_inv_d   = is_inv_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        error_d    = error_q;
        unpack_d   = unpack_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    is_inv_d = isInv_i;
                    unpack_d = unpack_op;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sq_valid_i) begin
                    result_d   = rnd_result;
                    overflow_d = rnd_ovf;
                    error_d    = 1'b0;
                    state_d    = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d   = QNAN;
                    overflow_d = 1'b0;
                    error_d    = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            is_inv_q   <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
            unpack_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_inv_q   <= is_inv_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
            unpack_q   <= unpack_d;
        end
    end

    assign ready_o     = (state_q == ST_IDLE);
    assign valid_o     = (state_q == ST_DONE);
    assign doSqrt_o    = (state_q == ST_ISSUE) & ~is_inv_q;
    assign doInvSqrt_o = (state_q == ST_ISSUE) & is_inv_q;
    assign result_o    = result_q;
    assign overflow_o  = overflow_q;
    assign error_o     = error_q;
    assign s_o         = unpack_q.s;
    assign extF_o      = unpack_q.ext_f;
    assign extE_o      = unpack_q.ext_e;
    assign nlz_o       = unpack_q.nlz;
    assign isZ_o       = unpack_q.is_z;
    assign isInf_o     = unpack_q.is_inf;
    assign isSNAN_o    = unpack_q.is_snan;
    assign isQNAN_o    = unpack_q.is_qnan;

endmodule

// File: tb/tb_lamp_fpu_sqrt_ctrl.sv
// Scoreboard bench for lamp_fpu_sqrt_ctrl: a directed driver plays the sqrt core,
// a negedge monitor pops expected completions whenever valid_o is high.
module tb_lamp_fpu_sqrt_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        isInv_i = 1'b0;
    logic [15:0] op_i = '0;
    logic        sq_s_i = 1'b0;
    logic [7:0]  sq_e_i = '0;
    logic [11:0] sq_f_i = '0;
    logic        sq_valid_i = 1'b0;
    logic        sq_isToRound_i = 1'b0;

    logic        ready_o, valid_o, overflow_o, error_o, doSqrt_o, doInvSqrt_o;
    logic [15:0] result_o;
    logic        s_o, isZ_o, isInf_o, isSNAN_o, isQNAN_o;
    logic [7:0]  extF_o;
    logic [8:0]  extE_o;
    logic [2:0]  nlz_o;

    lamp_fpu_sqrt_ctrl #(
        .LAMP_FLOAT_DW(16), .LAMP_FLOAT_E_DW(8), .LAMP_FLOAT_F_DW(7), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .isInv_i(isInv_i), .op_i(op_i),
        .ready_o(ready_o), .valid_o(valid_o), .result_o(result_o),
        .overflow_o(overflow_o), .error_o(error_o),
        .doSqrt_o(doSqrt_o), .doInvSqrt_o(doInvSqrt_o),
        .s_o(s_o), .extF_o(extF_o), .extE_o(extE_o), .nlz_o(nlz_o),
        .isZ_o(isZ_o), .isInf_o(isInf_o), .isSNAN_o(isSNAN_o), .isQNAN_o(isQNAN_o),
        .sq_s_i(sq_s_i), .sq_e_i(sq_e_i), .sq_f_i(sq_f_i),
        .sq_valid_i(sq_valid_i), .sq_isToRound_i(sq_isToRound_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    int   pulses_exp = 0;
    int   last_done_cyc = 0;
    bit   b2b_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (doSqrt_o || doInvSqrt_o) pulses++;

    // Monitor: every completion must match the oldest expected entry.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_valid) check("valid_single_cycle", valid_o, 0);
        if (valid_o) begin
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_valid", valid_o, 0);
            end else begin
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("overflow", overflow_o, e.ovf);
                check("error", error_o, e.err);
                check("valid_cycle", cyc, e.cyc);
            end
        end
        prev_valid = valid_o;
    end

    // lat = cycles from start pulse to sq_valid_i; 0 means the core never answers.
    task automatic run_op(input logic [15:0] op, input logic inv, input logic s,
                          input logic [7:0] e, input logic [11:0] f, input logic rnd,
                          input int lat, input logic [15:0] er, input logic eo,
                          input logic ee, input bit early, input bit poke);
        int   n;
        exp_t x;
        n = 0;
        while (!ready_o && n < 200) begin @(negedge clk); n++; end
        if (!ready_o) check("ready_timeout", ready_o, 1);
        req_i = 1'b1; isInv_i = inv; op_i = op;
        @(negedge clk);
        req_i = 1'b0;
        check("start_sqrt", doSqrt_o, !inv);
        check("start_inv", doInvSqrt_o, inv);
        if (b2b_chk) check("b2b_issue_cycle", cyc, last_done_cyc + 2);
        pulses_exp++;
        sq_s_i = s; sq_e_i = e; sq_f_i = f; sq_isToRound_i = rnd;
        x.res = er; x.ovf = eo; x.err = ee;
        x.cyc = cyc + ((lat == 0) ? TIMEOUT + 1 : lat + 1);
        sb.push_back(x);
        if (early) sq_valid_i = 1'b1;
        if (lat > 0) begin
            repeat (lat) begin
                @(negedge clk);
                sq_valid_i = 1'b0;
                if (poke) begin req_i = 1'b1; op_i = 16'h7F81; end
            end
            sq_valid_i = 1'b1;
            @(negedge clk);
            sq_valid_i = 1'b0;
            req_i = 1'b0;
        end else begin
            @(negedge clk);
            sq_valid_i = 1'b0;
        end
        n = 0;
        while (!valid_o && n < 200) begin @(negedge clk); n++; end
        if (!valid_o) check("valid_timeout", valid_o, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_flags", {overflow_o, error_o, doSqrt_o, doInvSqrt_o}, 0);
        check("rst_unpack", {s_o, extF_o, extE_o, nlz_o, isZ_o, isInf_o, isSNAN_o, isQNAN_o}, 0);
        rst = 1'b0;
        check("rst_ready", ready_o, 1);

        // sqrt(4) = 2 and 1/sqrt(4) = 0.5 as the core would deliver them.
        run_op(16'h4080, 1'b0, 1'b0, 8'h80, 12'b1_0000000_0000, 1'b0, 3, 16'h4000, 1'b0, 1'b0, 0, 0);
        check("unpack_4080_e", extE_o, 9'h081);
        check("unpack_4080_f", extF_o, 8'h80);
        check("unpack_4080_nlz", nlz_o, 0);
        run_op(16'h4080, 1'b1, 1'b0, 8'h7E, 12'b1_0000000_0000, 1'b0, 5, 16'h3F00, 1'b0, 1'b0, 0, 0);

        // Rounding cases.
        run_op(16'h3F80, 1'b0, 1'b0, 8'h7F, 12'b1_0000001_1000, 1'b1, 2, 16'h3F82, 1'b0, 1'b0, 0, 0);
        run_op(16'h3F80, 1'b0, 1'b0, 8'h7F, 12'b1_0000000_1000, 1'b1, 2, 16'h3F80, 1'b0, 1'b0, 0, 0);
        run_op(16'h3F80, 1'b0, 1'b0, 8'h7F, 12'b1_1111111_1000, 1'b1, 2, 16'h4000, 1'b0, 1'b0, 0, 0);
        run_op(16'h3F80, 1'b0, 1'b0, 8'hFE, 12'b1_1111111_1100, 1'b1, 2, 16'h7F80, 1'b1, 1'b0, 0, 0);
        run_op(16'h3F80, 1'b1, 1'b1, 8'h7F, 12'b1_0000000_0111, 1'b1, 1, 16'hBF80, 1'b0, 1'b0, 0, 0);

        // Unpack of subnormal, zero and NaN operands.
        run_op(16'h0001, 1'b0, 1'b0, 8'h00, 12'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 0, 0);
        check("unpack_0001_e", extE_o, 9'h001);
        check("unpack_0001_f", extF_o, 8'h01);
        check("unpack_0001_nlz", nlz_o, 7);
        check("unpack_0001_z", isZ_o, 0);
        run_op(16'h7F81, 1'b0, 1'b0, 8'hFF, 12'b1_1000000_0000, 1'b0, 1, 16'h7FC0, 1'b0, 1'b0, 0, 0);
        check("unpack_7f81_snan", isSNAN_o, 1);
        check("unpack_7f81_qnan", isQNAN_o, 0);
        check("unpack_7f81_inf", isInf_o, 0);
        run_op(16'h0000, 1'b0, 1'b0, 8'h00, 12'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 0, 0);
        check("unpack_0000_z", isZ_o, 1);
        check("unpack_0000_nlz", nlz_o, 7);
        check("unpack_0000_f", extF_o, 8'h00);
        run_op(16'hFF80, 1'b0, 1'b1, 8'hFF, 12'b1_0000000_0000, 1'b0, 1, 16'hFF80, 1'b0, 1'b0, 0, 0);
        check("unpack_ff80_inf", isInf_o, 1);
        check("unpack_ff80_s", s_o, 1);

        // Timeout, then core valid coincident with the counter limit.
        run_op(16'h4080, 1'b0, 1'b0, 8'h80, 12'b1_0000000_0000, 1'b0, 0, 16'h7FC0, 1'b0, 1'b1, 0, 0);
        run_op(16'h4080, 1'b0, 1'b0, 8'h80, 12'b1_0000000_0000, 1'b0, TIMEOUT, 16'h4000, 1'b0, 1'b0, 0, 0);

        // sq_valid_i during ISSUE is ignored; req_i during WAIT is dropped.
        run_op(16'h3F80, 1'b0, 1'b0, 8'h7F, 12'b1_0000001_0000, 1'b0, 4, 16'h3F81, 1'b0, 1'b0, 1, 0);
        run_op(16'h4080, 1'b1, 1'b0, 8'h7E, 12'b1_0000000_0000, 1'b0, 6, 16'h3F00, 1'b0, 1'b0, 0, 1);
        check("poke_keep_e", extE_o, 9'h081);
        check("poke_keep_snan", isSNAN_o, 0);

        // Request the cycle after DONE is accepted immediately.
        b2b_chk = 1'b1;
        run_op(16'h3F80, 1'b0, 1'b0, 8'h7F, 12'b1_0000000_0000, 1'b0, 1, 16'h3F80, 1'b0, 1'b0, 0, 0);
        b2b_chk = 1'b0;

        // Reset mid-WAIT aborts; a late core valid produces nothing.
        @(negedge clk);
        req_i = 1'b1; isInv_i = 1'b0; op_i = 16'h4080;
        @(negedge clk);
        req_i = 1'b0;
        check("abort_start", doSqrt_o, 1);
        pulses_exp++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", ready_o, 1);
        check("abort_unpack_cleared", extE_o, 0);
        sq_e_i = 8'h80; sq_f_i = 12'b1_0000000_0000; sq_isToRound_i = 1'b0;
        sq_valid_i = 1'b1;
        @(negedge clk);
        sq_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_ready_after", ready_o, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        check("start_pulse_count", pulses, pulses_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lamp_fpu_sqrt_ctrl.md
# lamp_fpu_sqrt_ctrl

Issue controller and round/pack back-end for the lampFPU square-root unit. It accepts a packed bfloat16 operand with a sqrt / inverse-sqrt request and unpacks it into sign, extended fraction, extended exponent, leading-zero count and class flags. It then drives the sqrt core's doSqrt/doInvSqrt start pulse and waits for the core's valid. Finally it applies round-to-nearest-even to the core's guard/round/sticky-extended result and returns a packed result with a one-cycle valid.

## Interface
- LAMP_FLOAT_DW, 16, packed float width
- LAMP_FLOAT_E_DW, 8, exponent width
- LAMP_FLOAT_F_DW, 7, stored fraction width
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before an error completion
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- req_i  in  1  request; accepted only while ready_o=1
- isInv_i  in  1  0 = sqrt, 1 = inverse sqrt; sampled with req_i
- op_i  in  LAMP_FLOAT_DW  packed operand; sampled with req_i
- ready_o  out  1  high only in IDLE
- valid_o  out  1  one-cycle completion pulse
- result_o  out  LAMP_FLOAT_DW  packed result; held until the next completion
- overflow_o / error_o  out  1 each  rounding carried into the all-ones exponent / timeout; both qualified by valid_o
- doSqrt_o, doInvSqrt_o  out  1 each  one-cycle start pulse to the core
- s_o  out  1; extF_o  out  F_DW+1; extE_o  out  E_DW+1; nlz_o  out  $clog2(F_DW+1)  unpacked operand
- isZ_o, isInf_o, isSNAN_o, isQNAN_o  out  1 each  operand class
- sq_s_i  in  1; sq_e_i  in  E_DW; sq_f_i  in  F_DW+5  core result
- sq_valid_i, sq_isToRound_i  in  1 each  core valid / core result needs rounding

## Operation
- Unpack, registered on acceptance:
  - s_o = op sign.
  - Normal operand (e≠0): extE_o = {0,e}, extF_o = {1,f}.
  - e = 0: extE_o = 1, extF_o = {0,f}.
  - nlz_o = leading zeros of extF_o, clamped to F_DW for zero.
  - isZ_o: e=0 and f=0. isInf_o: e all-ones and f=0.
  - NaN (e all-ones, f≠0): isQNAN_o if f[MSB]=1, otherwise isSNAN_o.
  - All unpack outputs stay stable from ISSUE through WAIT; the core uses them combinationally.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: on req_i, latch the operand and isInv_i, then go to ISSUE. Without req_i, stay in IDLE.
  - ISSUE: for exactly one cycle, doSqrt_o = ~isInv, doInvSqrt_o = isInv. Clear the timeout counter. Go to WAIT.
  - WAIT: counter increments each cycle.
    - On sq_valid_i: register the rounded result and go to DONE.
    - Else, when the counter reaches TIMEOUT_CYCLES-1: set result_o = QNAN (0x7FC0) and error_o=1, then go to DONE.
  - DONE: valid_o=1 for this cycle only, then go to IDLE.
- Core result field layout:
  - sq_f_i[F_DW+4] = hidden bit.
  - [F_DW+3:4] = fraction.
  - [3] = G. [2:1] = R bits. [0] = sticky.
- Rounding when sq_isToRound_i=1:
  - up = G & (|sq_f_i[2:0] | fraction LSB).
  - fraction+1 overflow: fraction becomes 0 and exponent+1.
  - If the exponent becomes all-ones: result is ±Inf (fraction 0) and overflow_o=1.
- When sq_isToRound_i=0: pass {sq_s_i, sq_e_i, sq_f_i[F_DW+3:4]} unchanged.

## Timing
- Reset: state IDLE; these outputs are 0: valid_o, result_o, overflow_o, error_o, doSqrt_o, doInvSqrt_o, and all unpack/class outputs. ready_o=1 in the first cycle after reset.
- rst during ISSUE/WAIT/DONE aborts the operation: no valid_o pulse, no start pulse. Any late sq_valid_i is ignored.
- Let req_i be accepted at edge T. Then the start pulse is in cycle T+1. If sq_valid_i arrives L cycles after the pulse, valid_o is high in cycle T+2+L.
- Requests while ready_o=0 are dropped; there is no queue.
- sq_valid_i outside WAIT is ignored, including a sq_valid_i coincident with the ISSUE cycle.
- If sq_valid_i arrives in the same cycle the counter reaches its limit, sq_valid_i wins and error_o=0.
- A back-to-back req_i can be accepted in the cycle after DONE, so the minimum request spacing is L+3 cycles.

## Test plan
- With the real core, request sqrt(0x4080) -> result_o 0x4000. Request invsqrt(0x4080) -> result_o 0x3F00. valid_o is a single-cycle pulse and doSqrt_o / doInvSqrt_o is exactly one pulse each.
- Stub core, sq_e=0x7F, sq_isToRound=1:
  - sq_f=1_0000001_1000 -> 0x3F82.
  - sq_f=1_0000000_1000 -> 0x3F80 (tie to even).
  - sq_f=1_1111111_1000 -> 0x4000 (carry into exponent).
- Stub with sq_e=0xFE and sq_f=1_1111111_1100 -> 0x7F80 with overflow_o=1.
- Unpack checks:
  - op 0x0001 -> extE_o=1, extF_o=0x01, nlz_o=7.
  - op 0x7F81 -> isSNAN_o=1.
  - op 0x0000 -> isZ_o=1, nlz_o=7.
- Stub never asserts sq_valid_i -> valid_o exactly TIMEOUT_CYCLES+1 cycles after the start pulse, with result_o 0x7FC0 and error_o=1.
- Boundary cases:
  - req_i during WAIT is ignored.
  - rst asserted mid-WAIT, then sq_valid_i -> no valid_o and ready_o=1.
  - A new request the cycle after DONE is accepted.
